// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. It owns the PC, the fetch-valid flag and a
// pending-redirect latch. The latch holds a branch that decode resolves while
// the front end is stalled, so that branch is not lost.
// Optional feature macro: IF_ADDR_EXC_EN enables the fetch address-error flag
// (if_exc_adel). When the macro is undefined, the flag is tied to 0.
module if_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter int unsigned STALL_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [32:0]            br_bus,
  output logic [32:0]            if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic                   if_exc_adel
);

  localparam logic [31:0] PC_RESET = RESET_VECTOR - PC_STEP;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic        r_ce, w_ce_n;
  logic        r_pend_valid, w_pend_valid_n;
  logic [31:0] r_pend_target, w_pend_target_n;
  logic        r_adel;
  logic        w_adel_n;
  logic        w_load;

  logic        w_hold;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_pc_seq;
  logic        w_unused_stall;

  assign w_hold         = stall[0];
  assign w_br_e         = br_bus[32];
  assign w_br_addr      = br_bus[31:0];
  assign w_pc_seq       = r_pc + PC_STEP;
  assign w_unused_stall = ^stall[STALL_W-1:1];

  // State, PC, fetch-valid and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET;
      r_ce          <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_ce          <= w_ce_n;
      r_pend_valid  <= w_pend_valid_n;
      r_pend_target <= w_pend_target_n;
    end
  end

  // Next-state and next-PC selection. Priority: hold > pending > branch > sequential.
  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_ce_n          = r_ce;
    w_pend_valid_n  = r_pend_valid;
    w_pend_target_n = r_pend_target;
    w_load          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_n = S_RUN;
        w_ce_n    = 1'b1;
        w_pc_n    = w_pc_seq;
      end
      S_RUN, S_HOLD: begin
        if (w_hold) begin
          if (w_br_e) begin
            w_pend_target_n = w_br_addr;
            w_pend_valid_n  = 1'b1;
            w_state_n       = S_REDIR;
          end else begin
            w_state_n = S_HOLD;
          end
        end else begin
          w_state_n = S_RUN;
          if (w_br_e) begin
            w_pc_n = w_br_addr;
            w_load = 1'b1;
          end else begin
            w_pc_n = w_pc_seq;
          end
        end
      end
      S_REDIR: begin
        if (w_hold) begin
          if (w_br_e) begin
            w_pend_target_n = w_br_addr;
          end
        end else begin
          // The pending target wins over any branch seen in the release cycle.
          w_state_n      = S_RUN;
          w_pend_valid_n = 1'b0;
          if (r_pend_valid) begin
            w_pc_n = r_pend_target;
            w_load = 1'b1;
          end else begin
            w_pc_n = w_pc_seq;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

`ifdef IF_ADDR_EXC_EN
  // The flag is updated only on redirect loads. Sequential fetch keeps the flag's current value.
  always_comb begin
    w_adel_n = r_adel;
    if (w_load) begin
      w_adel_n = |w_pc_n[1:0];
    end
  end

  // Address-error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adel <= 1'b0;
    end else begin
      r_adel <= w_adel_n;
    end
  end
`else
  // Feature disabled: no address-error detection.
  always_comb begin
    w_adel_n = 1'b0;
    r_adel   = w_adel_n | (w_load & 1'b0);
  end
`endif

  assign if_exc_adel     = r_adel;
  assign inst_sram_en    = r_ce & ~r_adel;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign if_to_id_bus    = {r_ce, r_pc};

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch. It uses hand-computed expected PCs.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_exc_adel;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .if_exc_adel     (if_exc_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check that the outputs match the expected ce, pc and address-error flag.
  task automatic expect_out(input string tag, input logic ce, input logic [31:0] pc, input logic adel);
    check({tag, ".addr"}, 64'(inst_sram_addr), 64'(pc));
    check({tag, ".bus"},  64'(if_to_id_bus),   64'({ce, pc}));
    check({tag, ".en"},   64'(inst_sram_en),   64'(ce & ~adel));
    check({tag, ".adel"}, 64'(if_exc_adel),    64'(adel));
  endtask

  task automatic drive(input logic st, input logic be, input logic [31:0] ba);
    stall  = {5'b0, st};
    br_bus = {be, ba};
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    step(); step(); step();
    expect_out("reset", 1'b0, 32'hBFBF_FFFC, 1'b0);
    check("wen",   64'(inst_sram_wen),   64'(0));
    check("wdata", 64'(inst_sram_wdata), 64'(0));

    rst = 1'b0;
    expect_out("rel_c0", 1'b0, 32'hBFBF_FFFC, 1'b0);
    step(); expect_out("rel_c1", 1'b1, 32'hBFC0_0000, 1'b0);
    step(); expect_out("rel_c2", 1'b1, 32'hBFC0_0004, 1'b0);
    step(); expect_out("rel_c3", 1'b1, 32'hBFC0_0008, 1'b0);

    // Taken branch with no stall.
    drive(1'b0, 1'b1, 32'hBFC0_0100);
    step(); expect_out("br_tgt", 1'b1, 32'hBFC0_0100, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("br_seq", 1'b1, 32'hBFC0_0104, 1'b0);

    // Stall with no branch pending.
    drive(1'b0, 1'b1, 32'hBFC0_0010);
    step(); expect_out("to_0010", 1'b1, 32'hBFC0_0010, 1'b0);
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_out("st_h1", 1'b1, 32'hBFC0_0010, 1'b0);
    step(); expect_out("st_h2", 1'b1, 32'hBFC0_0010, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("st_rel", 1'b1, 32'hBFC0_0014, 1'b0);

    // Branch during stall. A branch in the release cycle is ignored.
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_out("bs_c1", 1'b1, 32'hBFC0_0014, 1'b0);
    drive(1'b1, 1'b1, 32'hBFC0_0200);
    step(); expect_out("bs_c2", 1'b1, 32'hBFC0_0014, 1'b0);
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_out("bs_c3", 1'b1, 32'hBFC0_0014, 1'b0);
    drive(1'b0, 1'b1, 32'hBFC0_0500);
    step(); expect_out("bs_rel", 1'b1, 32'hBFC0_0200, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("bs_seq", 1'b1, 32'hBFC0_0204, 1'b0);

    // Branch and stall rise together. The latest branch address wins.
    drive(1'b1, 1'b1, 32'hBFC0_0600);
    step(); expect_out("sim_c1", 1'b1, 32'hBFC0_0204, 1'b0);
    drive(1'b1, 1'b1, 32'hBFC0_0700);
    step(); expect_out("sim_c2", 1'b1, 32'hBFC0_0204, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("sim_rel", 1'b1, 32'hBFC0_0700, 1'b0);
    step(); expect_out("sim_seq", 1'b1, 32'hBFC0_0704, 1'b0);

    // Branch in a HOLD release cycle with nothing pending is taken.
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_out("hr_hold", 1'b1, 32'hBFC0_0704, 1'b0);
    drive(1'b0, 1'b1, 32'hBFC0_0800);
    step(); expect_out("hr_br", 1'b1, 32'hBFC0_0800, 1'b0);

    // Reset in the middle of REDIR discards the pending redirect.
    drive(1'b1, 1'b1, 32'hBFC0_0300);
    step(); expect_out("rr_pend", 1'b1, 32'hBFC0_0800, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    step(); expect_out("rr_rst", 1'b0, 32'hBFBF_FFFC, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("rr_c1", 1'b1, 32'hBFC0_0000, 1'b0);
    step(); expect_out("rr_c2", 1'b1, 32'hBFC0_0004, 1'b0);

    // PC wraps modulo 2^32.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(); expect_out("wr_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("wr_zero", 1'b1, 32'h0000_0000, 1'b0);

`ifdef IF_ADDR_EXC_EN
    // Misaligned branch raises the flag. An aligned branch clears it.
    drive(1'b0, 1'b1, 32'hBFC0_0102);
    step(); expect_out("ae_set", 1'b1, 32'hBFC0_0102, 1'b1);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("ae_seq", 1'b1, 32'hBFC0_0106, 1'b1);
    drive(1'b0, 1'b1, 32'hBFC0_0400);
    step(); expect_out("ae_clr", 1'b1, 32'hBFC0_0400, 1'b0);
`else
    // With the feature disabled, misaligned addresses are issued unchanged.
    drive(1'b0, 1'b1, 32'hBFC0_0102);
    step(); expect_out("ae_off", 1'b1, 32'hBFC0_0102, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step(); expect_out("ae_off_seq", 1'b1, 32'hBFC0_0106, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; drives the instruction SRAM and the IF->ID bus.
- Consumes the branch redirect bus and the stall vector that the decode stage produces.
- Owns the PC register, the fetch-valid flag and a pending-redirect latch, so branches resolved in decode while the front end is stalled are not lost.
- Sits between the pipeline controller/decode and the synchronous instruction SRAM (1-cycle read latency; data is consumed by decode).

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first instruction address fetched after reset.
- PC_STEP, 32'd4, sequential PC increment.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- stall  input  `StallBus  stall vector; bit 0 = hold PC (`Stop = 1)
- br_bus  input  `BR_WD  {br_e[32], br_addr[31:0]} from decode
- if_to_id_bus  output  `IF_TO_ID_WD  {ce[32], pc[31:0]}
- inst_sram_en  output  1  instruction SRAM enable
- inst_sram_wen  output  4  byte write enables, always 4'b0000
- inst_sram_addr  output  32  fetch address
- inst_sram_wdata  output  32  always 32'b0
- if_exc_adel  output  1  fetch address-error flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on posedge clk.
- Reset values: pc = RESET_VECTOR - PC_STEP (32'hBFBF_FFFC); ce = 0; pending_valid = 0; pending_target = 0; state = IDLE; if_exc_adel = 0.
- Combinational outputs:
  - inst_sram_en = ce & ~if_exc_adel.
  - inst_sram_addr = pc.
  - if_to_id_bus = {ce, pc}.
- States:
  - IDLE: post-reset, ce = 0. On the first cycle with rst = 0, go to RUN: ce <= 1 and pc <= pc + PC_STEP, so RESET_VECTOR is fetched with 1-cycle latency from reset release. Stall is ignored in IDLE.
  - RUN: stall[0] = 0, no pending redirect. Next pc = br_e ? br_addr : pc + PC_STEP. On stall[0] = 1, go to HOLD.
  - HOLD: pc and ce frozen; SRAM keeps being re-addressed with the same pc.
    - br_e = 1 in any HOLD cycle: pending_target <= br_addr, pending_valid <= 1, go to REDIR. The latest br_addr wins on repeat assertions.
    - stall[0] released with no pending redirect: back to RUN, with next pc computed as in RUN.
  - REDIR: frozen as in HOLD; pending_target is still overwritten on further br_e.
    - On stall[0] = 0: pc <= pending_target, pending_valid <= 0, go to RUN.
    - A br_e in the release cycle is ignored; the pending target has priority.
- Next-pc priority in every state: rst > stall[0] hold > pending redirect > br_e > sequential.
- Arithmetic: 32-bit, wraps modulo 2^32. pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Simultaneous events:
  - br_e and stall[0] rising in the same cycle: captured into pending, pc unchanged.
  - rst with anything: reset wins and clears pending.
- Reset mid-operation (any state): returns to IDLE with reset values; pending redirect discarded.
- Branch delay slot: the instruction after the branch is fetched normally. Redirect takes effect on the pc following the cycle br_e is seen. No flush is generated here.

Optional Feature:
- Macro: IF_ADDR_EXC_EN.
- Defined:
  - Any pc loaded with pc[1:0] != 2'b00 (from br_addr or pending_target) sets if_exc_adel = 1 in the same cycle that pc becomes visible.
  - While if_exc_adel = 1: inst_sram_en is forced 0, ce stays 1, and the fetch continues sequentially from the misaligned pc.
  - The flag clears when an aligned pc is loaded, or on rst.
- Not defined: if_exc_adel is tied 0; misaligned addresses are issued to SRAM unchanged.

Test Plan:
- Reset release: rst 1->0 -> cycle 0 ce = 0, pc = BFBF_FFFC; cycle 1 ce = 1, inst_sram_addr = BFC0_0000; cycle 2 addr = BFC0_0004.
- Taken branch, no stall: br_bus = {1, 32'hBFC0_0100} while pc = BFC0_0008 -> next cycle addr = BFC0_0100, then BFC0_0104.
- Branch during stall: stall[0] = 1 for 3 cycles with br_e = 1 and br_addr = BFC0_0200 in cycle 2 -> addr held at its current value for all 3 cycles; cycle after release addr = BFC0_0200; a br_e in the release cycle is ignored.
- Stall without branch: pc = BFC0_0010, stall[0] = 1 for 2 cycles -> addr = BFC0_0010 throughout; after release BFC0_0014.
- Reset mid-REDIR: pending BFC0_0300, rst = 1 for 1 cycle -> pending cleared, ce = 0, then fetch resumes at BFC0_0000 (never BFC0_0300).
- IF_ADDR_EXC_EN defined: br_addr = BFC0_0102 -> if_exc_adel = 1, inst_sram_en = 0, ce = 1; a branch to BFC0_0400 clears the flag and re-enables SRAM.
